// File: rtl/elevator_motion_ctrl.sv
// Car motion controller: latches button calls, runs the move/arrive/door
// FSM and owns the current floor register fed back to the request solver.
// Ports: clk, rst_n (sync, active-low); upPress/downPress/floorPress in;
// requestFromUp/requestFromDown in; upRequest/downRequest/floorRequest,
// floor, doorOpen, movingUp, movingDown, arrive out.
module elevator_motion_ctrl #(
  parameter int MAX_FLOOR   = 8,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MAX_FLOOR-1:0]         upPress,
  input  logic [MAX_FLOOR-1:0]         downPress,
  input  logic [MAX_FLOOR-1:0]         floorPress,
  input  logic                         requestFromUp,
  input  logic                         requestFromDown,
  output logic [MAX_FLOOR-1:0]         upRequest,
  output logic [MAX_FLOOR-1:0]         downRequest,
  output logic [MAX_FLOOR-1:0]         floorRequest,
  output logic [$clog2(MAX_FLOOR)-1:0] floor,
  output logic                         doorOpen,
  output logic                         movingUp,
  output logic                         movingDown,
  output logic                         arrive
);

  localparam int FW = $clog2(MAX_FLOOR);
  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [FW-1:0] TOP = FW'(MAX_FLOOR - 1);
  localparam logic [MW-1:0] M_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [MAX_FLOOR-1:0] ONE = MAX_FLOOR'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_ARRIVE,
    S_DOOR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_dir;
  logic                  w_nextDir;
  logic [FW-1:0]         r_floor;
  logic [MW-1:0]         r_moveCnt;
  logic [DW-1:0]         r_doorCnt;
  logic [MAX_FLOOR-1:0]  r_upReq;
  logic [MAX_FLOOR-1:0]  r_dnReq;
  logic [MAX_FLOOR-1:0]  r_flReq;
  logic [MAX_FLOOR-1:0]  w_clr;
  logic                  w_hereReq;
  logic                  w_herePress;
  logic                  w_reqUp;
  logic                  w_reqDn;
  logic                  w_moveDone;
  logic                  w_doorDone;

  assign w_hereReq   = r_upReq[r_floor] | r_dnReq[r_floor]
                     | r_flReq[r_floor];
  assign w_herePress = upPress[r_floor] | downPress[r_floor]
                     | floorPress[r_floor];
  // Solver flags are masked at the shaft ends so no move overruns.
  assign w_reqUp     = requestFromUp & (r_floor != TOP);
  assign w_reqDn     = requestFromDown & (r_floor != '0);
  assign w_moveDone  = (r_moveCnt == M_LAST);
  assign w_doorDone  = (r_doorCnt == D_LAST);
  // The current floor is cleared on DOOR entry and for the whole DOOR
  // stay, so a same-cycle press there is dropped.
  assign w_clr = ((w_next == S_DOOR) || (r_state == S_DOOR))
               ? (ONE << r_floor) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_nextDir = r_dir;
    unique case (r_state)
      S_IDLE: begin
        if (w_hereReq) begin
          w_next = S_DOOR;
        end else if (r_dir ? w_reqUp : w_reqDn) begin
          w_next = S_MOVE;
        end else if (r_dir ? w_reqDn : w_reqUp) begin
          w_next    = S_MOVE;
          w_nextDir = ~r_dir;
        end
      end
      S_MOVE: begin
        if (w_moveDone) w_next = S_ARRIVE;
      end
      S_ARRIVE: begin
        if (w_hereReq)                       w_next = S_DOOR;
        else if (r_dir ? w_reqUp : w_reqDn)  w_next = S_MOVE;
        else                                 w_next = S_IDLE;
      end
      S_DOOR: begin
        if (!w_herePress && w_doorDone) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    doorOpen   = (r_state == S_DOOR);
    movingUp   = (r_state == S_MOVE) && r_dir;
    movingDown = (r_state == S_MOVE) && !r_dir;
    arrive     = (r_state == S_ARRIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir     <= 1'b1;
      r_floor   <= '0;
      r_moveCnt <= '0;
      r_doorCnt <= '0;
      r_upReq   <= '0;
      r_dnReq   <= '0;
      r_flReq   <= '0;
    end else begin
      r_upReq <= (r_upReq | upPress) & ~w_clr;
      r_dnReq <= (r_dnReq | downPress) & ~w_clr;
      r_flReq <= (r_flReq | floorPress) & ~w_clr;
      r_dir   <= w_nextDir;
      if (r_state == S_MOVE) begin
        if (w_moveDone) begin
          r_moveCnt <= '0;
          if (r_dir && (r_floor != TOP))
            r_floor <= r_floor + 1'b1;
          else if (!r_dir && (r_floor != '0))
            r_floor <= r_floor - 1'b1;
        end else begin
          r_moveCnt <= r_moveCnt + 1'b1;
        end
      end else begin
        r_moveCnt <= '0;
      end
      // A press at this floor holds the door by restarting the count.
      if ((r_state == S_DOOR) && !w_herePress && !w_doorDone)
        r_doorCnt <= r_doorCnt + 1'b1;
      else
        r_doorCnt <= '0;
    end
  end

  assign upRequest    = r_upReq;
  assign downRequest  = r_dnReq;
  assign floorRequest = r_flReq;
  assign floor        = r_floor;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Bench for elevator_motion_ctrl: step table with a scoreboard queue,
// a simple request-solver model, and a shaft-end override sequence.
module tb_elevator_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] upPress, downPress, floorPress;
  logic       requestFromUp, requestFromDown;
  logic [7:0] upRequest, downRequest, floorRequest;
  logic [2:0] floor;
  logic       doorOpen, movingUp, movingDown, arrive;
  logic       ovUp;

  always #5 clk = ~clk;

  elevator_motion_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .upPress         (upPress),
    .downPress       (downPress),
    .floorPress      (floorPress),
    .requestFromUp   (requestFromUp),
    .requestFromDown (requestFromDown),
    .upRequest       (upRequest),
    .downRequest     (downRequest),
    .floorRequest    (floorRequest),
    .floor           (floor),
    .doorOpen        (doorOpen),
    .movingUp        (movingUp),
    .movingDown      (movingDown),
    .arrive          (arrive)
  );

  // Request solver: any pending call above / below the current floor.
  always_comb begin
    logic [7:0] p;
    p = upRequest | downRequest | floorRequest;
    requestFromUp   = ovUp;
    requestFromDown = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (p[i] && (i > int'(floor))) requestFromUp = 1'b1;
      if (p[i] && (i < int'(floor))) requestFromDown = 1'b1;
    end
  end

  typedef struct {
    int         n;
    logic       rst;
    logic [7:0] up, dn, fl;
    logic [2:0] efl;
    logic       edoor, emu, emd, earr;
    logic [7:0] eup, edn, efr;
  } vec_t;

  vec_t tbl[52];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t V(
    int n, logic rst,
    logic [7:0] up, logic [7:0] dn, logic [7:0] fl,
    logic [2:0] efl, logic d, logic mu, logic md, logic ar,
    logic [7:0] eu, logic [7:0] ed, logic [7:0] ef);
    vec_t v;
    v.n = n; v.rst = rst; v.up = up; v.dn = dn; v.fl = fl;
    v.efl = efl; v.edoor = d; v.emu = mu; v.emd = md;
    v.earr = ar; v.eup = eu; v.edn = ed; v.efr = ef;
    return v;
  endfunction

  task automatic chk(string nm, int idx,
                     logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic run(int lo, int hi);
    for (int k = lo; k <= hi; k++) begin
      vec_t e;
      @(negedge clk);
      rst_n      = tbl[k].rst;
      upPress    = tbl[k].up;
      downPress  = tbl[k].dn;
      floorPress = tbl[k].fl;
      exp_q.push_back(tbl[k]);
      for (int c = 0; c < tbl[k].n; c++) begin
        @(posedge clk);
        #1;
        upPress    = '0;
        downPress  = '0;
        floorPress = '0;
        chk("excl", k, 8'((movingUp && movingDown) ||
            (doorOpen && (movingUp || movingDown))), 8'd0);
      end
      e = exp_q.pop_front();
      chk("floor",  k, 8'(floor),      8'(e.efl));
      chk("door",   k, 8'(doorOpen),   8'(e.edoor));
      chk("mvUp",   k, 8'(movingUp),   8'(e.emu));
      chk("mvDn",   k, 8'(movingDown), 8'(e.emd));
      chk("arrive", k, 8'(arrive),     8'(e.earr));
      chk("upReq",  k, upRequest,      e.eup);
      chk("dnReq",  k, downRequest,    e.edn);
      chk("flReq",  k, floorRequest,   e.efr);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    upPress = '0; downPress = '0; floorPress = '0;
    ovUp = 1'b0;
    // reset
    tbl[0]  = V(2, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0);
    // cab call to 3 from 0
    tbl[1]  = V(1, 1, 0, 0, 8'h08, 0, 0, 0, 0, 0, 0, 0, 8'h08);
    tbl[2]  = V(1, 1, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 8'h08);
    tbl[3]  = V(3, 1, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 8'h08);
    tbl[4]  = V(1, 1, 0, 0, 0,     1, 0, 0, 0, 1, 0, 0, 8'h08);
    tbl[5]  = V(1, 1, 0, 0, 0,     1, 0, 1, 0, 0, 0, 0, 8'h08);
    tbl[6]  = V(4, 1, 0, 0, 0,     2, 0, 0, 0, 1, 0, 0, 8'h08);
    tbl[7]  = V(5, 1, 0, 0, 0,     3, 0, 0, 0, 1, 0, 0, 8'h08);
    tbl[8]  = V(1, 1, 0, 0, 0,     3, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = V(2, 1, 0, 0, 0,     3, 1, 0, 0, 0, 0, 0, 0);
    // door hold at 3
    tbl[10] = V(1, 1, 0, 0, 8'h08, 3, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = V(2, 1, 0, 0, 0,     3, 1, 0, 0, 0, 0, 0, 0);
    tbl[12] = V(1, 1, 0, 0, 0,     3, 0, 0, 0, 0, 0, 0, 0);
    // reset mid-move
    tbl[13] = V(1, 1, 0, 8'h40, 8'h20,
                3, 0, 0, 0, 0, 0, 8'h40, 8'h20);
    tbl[14] = V(1, 1, 0, 0, 0,     3, 0, 1, 0, 0, 0, 8'h40, 8'h20);
    tbl[15] = V(2, 1, 0, 0, 0,     3, 0, 1, 0, 0, 0, 8'h40, 8'h20);
    tbl[16] = V(2, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0);
    // go to 2, then direction hold: up[5] before cab 0
    tbl[17] = V(1, 1, 0, 0, 8'h04, 0, 0, 0, 0, 0, 0, 0, 8'h04);
    tbl[18] = V(10, 1, 0, 0, 0,    2, 0, 0, 0, 1, 0, 0, 8'h04);
    tbl[19] = V(1, 1, 0, 0, 0,     2, 1, 0, 0, 0, 0, 0, 0);
    tbl[20] = V(3, 1, 0, 0, 0,     2, 0, 0, 0, 0, 0, 0, 0);
    tbl[21] = V(1, 1, 8'h20, 0, 8'h01,
                2, 0, 0, 0, 0, 8'h20, 0, 8'h01);
    tbl[22] = V(1, 1, 0, 0, 0,     2, 0, 1, 0, 0, 8'h20, 0, 8'h01);
    tbl[23] = V(14, 1, 0, 0, 0,    5, 0, 0, 0, 1, 8'h20, 0, 8'h01);
    tbl[24] = V(1, 1, 0, 0, 0,     5, 1, 0, 0, 0, 0, 0, 8'h01);
    tbl[25] = V(3, 1, 0, 0, 0,     5, 0, 0, 0, 0, 0, 0, 8'h01);
    tbl[26] = V(1, 1, 0, 0, 0,     5, 0, 0, 1, 0, 0, 0, 8'h01);
    tbl[27] = V(4, 1, 0, 0, 0,     4, 0, 0, 0, 1, 0, 0, 8'h01);
    tbl[28] = V(20, 1, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0, 8'h01);
    tbl[29] = V(1, 1, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0);
    tbl[30] = V(3, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0);
    // dir flip from down to up, travel to 4
    tbl[31] = V(1, 1, 0, 0, 8'h10, 0, 0, 0, 0, 0, 0, 0, 8'h10);
    tbl[32] = V(1, 1, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 8'h10);
    tbl[33] = V(19, 1, 0, 0, 0,    4, 0, 0, 0, 1, 0, 0, 8'h10);
    tbl[34] = V(1, 1, 0, 0, 0,     4, 1, 0, 0, 0, 0, 0, 0);
    tbl[35] = V(3, 1, 0, 0, 0,     4, 0, 0, 0, 0, 0, 0, 0);
    // simultaneous up[4] and cab 6 at floor 4
    tbl[36] = V(1, 1, 8'h10, 0, 8'h40,
                4, 0, 0, 0, 0, 8'h10, 0, 8'h40);
    tbl[37] = V(1, 1, 0, 0, 0,     4, 1, 0, 0, 0, 0, 0, 8'h40);
    tbl[38] = V(3, 1, 0, 0, 0,     4, 0, 0, 0, 0, 0, 0, 8'h40);
    tbl[39] = V(1, 1, 0, 0, 0,     4, 0, 1, 0, 0, 0, 0, 8'h40);
    tbl[40] = V(9, 1, 0, 0, 0,     6, 0, 0, 0, 1, 0, 0, 8'h40);
    tbl[41] = V(1, 1, 0, 0, 0,     6, 1, 0, 0, 0, 0, 0, 0);
    tbl[42] = V(3, 1, 0, 0, 0,     6, 0, 0, 0, 0, 0, 0, 0);
    // up to the top floor
    tbl[43] = V(1, 1, 0, 0, 8'h80, 6, 0, 0, 0, 0, 0, 0, 8'h80);
    tbl[44] = V(5, 1, 0, 0, 0,     7, 0, 0, 0, 1, 0, 0, 8'h80);
    tbl[45] = V(1, 1, 0, 0, 0,     7, 1, 0, 0, 0, 0, 0, 0);
    tbl[46] = V(3, 1, 0, 0, 0,     7, 0, 0, 0, 0, 0, 0, 0);
    // press at 7, then same-cycle presses at 7 and 1 in DOOR
    tbl[47] = V(1, 1, 8'h80, 0, 0, 7, 0, 0, 0, 0, 8'h80, 0, 0);
    tbl[48] = V(1, 1, 0, 0, 0,     7, 1, 0, 0, 0, 0, 0, 0);
    tbl[49] = V(1, 1, 0, 0, 8'h82, 7, 1, 0, 0, 0, 0, 0, 8'h02);
    tbl[50] = V(3, 1, 0, 0, 0,     7, 0, 0, 0, 0, 0, 0, 8'h02);
    tbl[51] = V(1, 1, 0, 0, 0,     7, 0, 0, 1, 0, 0, 0, 8'h02);

    run(0, 46);

    // Solver wrongly claims a call above the top: car must stay put.
    @(negedge clk);
    ovUp = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("bound_floor", 100 + c, 8'(floor), 8'd7);
      chk("bound_noUp",  100 + c, 8'(movingUp), 8'd0);
    end
    @(negedge clk);
    ovUp = 1'b0;

    run(47, 51);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
